// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter (LSB first) fed by a small byte FIFO.
// Bytes written on WR_EN are queued; frames go out back-to-back while the FIFO holds data.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_IDLE  | line idle high, waiting for a queued byte
//   S_START | start bit (low) for one bit period
//   S_DATA  | eight data bits, LSB first
//   S_STOP  | stop bit (high); chains straight into the next frame

module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       WR_EN,
    input  logic [7:0] DIN,
    output logic       FULL,
    output logic       EMPTY,
    output logic       BUSY,
    output logic       TX
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic             push;
    logic             pop;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic             bit_end;

    // A write while full is dropped even when a pop happens on the same edge.
    assign push = WR_EN && !FULL;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= DIN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            FULL   <= 1'b0;
            EMPTY  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            FULL  <= (count_next == DEPTH_CNT);
            EMPTY <= (count_next == '0);
        end
    end

    assign bit_end = (baud_cnt == CNT_LAST);

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        pop        = 1'b0;

        case (state)
            S_IDLE: begin
                baud_next = '0;
                if (!EMPTY) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    bit_next   = '0;
                    state_next = S_START;
                end
            end

            S_START: begin
                if (bit_end) begin
                    baud_next  = '0;
                    state_next = S_DATA;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        shift_next = shift >> 1;
                        bit_next   = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    baud_next = '0;
                    // Chain the next frame with no idle gap when data is waiting.
                    if (!EMPTY) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        bit_next   = '0;
                        state_next = S_START;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end

            default: begin
                state_next = S_IDLE;
                baud_next  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
        end
    end

    // Line and busy flag are registered from the current state, so they trail it by one edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            TX   <= 1'b1;
            BUSY <= 1'b0;
        end else begin
            case (state)
                S_START: TX <= 1'b0;
                S_DATA:  TX <= shift[0];
                default: TX <= 1'b1;
            endcase
            BUSY <= (state != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed writes feed an expected-byte queue; a line
// monitor decodes TX frames mid-bit and checks them against that queue.
`timescale 1ns/1ps

module tb_uart_tx_fifo;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] din   = 8'h00;
    logic       full;
    logic       empty;
    logic       busy;
    logic       tx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    int         starts[$];

    uart_tx_fifo #(
        .CLK_FREQ  (1000),
        .BAUD      (100),
        .FIFO_DEPTH(4)
    ) dut (
        .CLK  (clk),
        .RST  (rst),
        .WR_EN(wr_en),
        .DIN  (din),
        .FULL (full),
        .EMPTY(empty),
        .BUSY (busy),
        .TX   (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Line monitor: offset 0 is the first low sample; bits sampled at offset 10*k+5.
    bit         mon_active = 1'b0;
    int         mon_off    = 0;
    logic [7:0] mon_byte   = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_off    = 0;
                starts.push_back(cyc);
            end
        end else begin
            mon_off++;
            if (mon_off == 5) begin
                chk("start_bit", tx, 0);
            end else if (mon_off >= 15 && mon_off <= 85 && (mon_off % 10) == 5) begin
                mon_byte[(mon_off - 15) / 10] = tx;
            end else if (mon_off == 95) begin
                chk("stop_bit", tx, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got %02h expected no frame (cycle %0d)", mon_byte, cyc);
                end else begin
                    chk("frame_data", mon_byte, exp_q.pop_front());
                end
            end
            if (mon_off == 99) mon_active = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr1(input logic [7:0] b);
        @(negedge clk);
        wr_en = 1'b1;
        din   = b;
        exp_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
        din   = ~b;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while (!(busy === 1'b0 && empty === 1'b1 && tx === 1'b1) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle_in_time"}, int'(n < limit), 1);
    endtask

    task automatic count_low(input int n, output int lows);
        lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx === 1'b0) lows++;
        end
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: run still going at %0t, checks=%0d", $time, checks);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b4[6];
        logic [7:0] b6[4];
        int         lows;
        int         bcnt;

        // 1: reset then a long idle stretch
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            chk("t1_idle_flags", {tx, busy, empty, full}, 4'b1010);
        end

        // 2: single byte 0x55, latency and busy window
        @(negedge clk);
        wr_en = 1'b1;
        din   = 8'h55;
        exp_q.push_back(8'h55);
        @(negedge clk);
        wr_en = 1'b0;
        din   = 8'hAA;
        chk("t2_empty_e0", empty, 0);
        chk("t2_tx_e0", tx, 1);
        @(negedge clk);
        chk("t2_tx_e1", tx, 1);
        chk("t2_busy_e1", busy, 0);
        @(negedge clk);
        chk("t2_tx_e2", tx, 0);
        chk("t2_busy_e2", busy, 1);
        chk("t2_empty_e2", empty, 1);
        bcnt = 0;
        for (int k = 3; k <= 101; k++) begin
            @(negedge clk);
            if (busy === 1'b1) bcnt++;
        end
        chk("t2_busy_len", bcnt, 99);
        @(negedge clk);
        chk("t2_busy_e102", busy, 0);
        chk("t2_tx_e102", tx, 1);
        wait_idle(50, "t2");

        // 3: all-zero then all-one byte; low-time gives the bit width
        wr1(8'h00);
        count_low(110, lows);
        chk("t3_zero_low_cycles", lows, 90);
        wait_idle(50, "t3a");
        wr1(8'hFF);
        count_low(110, lows);
        chk("t3_ones_low_cycles", lows, 10);
        wait_idle(50, "t3b");

        // 4: overflow burst, F is dropped
        starts.delete();
        b4 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 4) chk("t4_full_e3", full, 0);
            if (i == 5) chk("t4_full_e4", full, 1);
            wr_en = 1'b1;
            din   = b4[i];
            if (i < 5) exp_q.push_back(b4[i]);
        end
        @(negedge clk);
        wr_en = 1'b0;
        din   = 8'h00;
        chk("t4_full_e5", full, 1);
        chk("t4_empty_e5", empty, 0);
        tick(20);
        wait_idle(700, "t4");
        chk("t4_frame_count", starts.size(), 5);
        for (int i = 1; i < starts.size(); i++)
            chk("t4_frame_gap", starts[i] - starts[i-1], 100);
        chk("t4_queue_drained", exp_q.size(), 0);

        // 5: reset during data bit 3 of the first of two queued frames
        starts.delete();
        @(negedge clk);
        wr_en = 1'b1;
        din   = 8'h3C;
        exp_q.push_back(8'h3C);
        @(negedge clk);
        din   = 8'hA5;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        wr_en = 1'b0;
        din   = 8'h00;
        tick(45);
        chk("t5_busy_before_rst", busy, 1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("t5_tx_after_rst", tx, 1);
        chk("t5_busy_after_rst", busy, 0);
        chk("t5_empty_after_rst", empty, 1);
        chk("t5_full_after_rst", full, 0);
        rst = 1'b0;
        count_low(300, lows);
        chk("t5_no_frames_low_cycles", lows, 0);
        chk("t5_frame_starts", starts.size(), 1);
        wr1(8'h81);
        tick(5);
        wait_idle(150, "t5");

        // 6: push on the same edge as the STOP-end pop with 3 entries queued
        starts.delete();
        b6 = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_en = 1'b1;
            din   = b6[i];
            exp_q.push_back(b6[i]);
        end
        @(negedge clk);
        wr_en = 1'b0;
        chk("t6_full_e3", full, 0);
        chk("t6_empty_e3", empty, 0);
        tick(97);
        wr_en = 1'b1;
        din   = 8'h55;
        exp_q.push_back(8'h55);
        @(negedge clk);
        wr_en = 1'b0;
        din   = 8'h00;
        chk("t6_full_collision", full, 0);
        chk("t6_empty_collision", empty, 0);
        @(negedge clk);
        chk("t6_next_start_contiguous", tx, 0);
        tick(5);
        wait_idle(800, "t6");
        chk("t6_frame_count", starts.size(), 5);
        for (int i = 1; i < starts.size(); i++)
            chk("t6_frame_gap", starts[i] - starts[i-1], 100);

        tick(10);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
